// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin, burst-limited arbiter for the shared 16x16 data memory
module dmem_arbiter #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, CORE, HOST} state_t;

    localparam logic       OWN_CORE = 1'b0;
    localparam logic       OWN_HOST = 1'b1;
    localparam logic [3:0] MAXB     = 4'(MAX_BURST);

    state_t              state_q, state_d;
    logic [3:0]          burst_q, burst_d;
    logic                last_q, last_d;
    logic                gnt_c, gnt_h;
    logic                core_rvalid_q, host_rvalid_q;
    logic [ADDR_W-1:0]   addr_hold_q;
    logic [DATA_W-1:0]   wdata_hold_q;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        last_d  = last_q;
        gnt_c   = 1'b0;
        gnt_h   = 1'b0;
        if (!sys_rst) begin
            case (state_q)
                IDLE: begin
                    // On a tie the side that was not served last wins
                    if (core_req && (!host_req || last_q == OWN_HOST)) begin
                        gnt_c   = 1'b1;
                        state_d = CORE;
                        burst_d = 4'd1;
                    end else if (host_req) begin
                        gnt_h   = 1'b1;
                        state_d = HOST;
                        burst_d = 4'd1;
                    end
                end
                CORE: begin
                    if (core_req && (!host_req || burst_q < MAXB)) begin
                        gnt_c   = 1'b1;
                        burst_d = (burst_q >= MAXB) ? MAXB : burst_q + 4'd1;
                    end else if (host_req) begin
                        gnt_h   = 1'b1;
                        state_d = HOST;
                        burst_d = 4'd1;
                        last_d  = OWN_CORE;
                    end else begin
                        state_d = IDLE;
                        burst_d = 4'd0;
                        last_d  = OWN_CORE;
                    end
                end
                HOST: begin
                    if (host_req && (!core_req || burst_q < MAXB)) begin
                        gnt_h   = 1'b1;
                        burst_d = (burst_q >= MAXB) ? MAXB : burst_q + 4'd1;
                    end else if (core_req) begin
                        gnt_c   = 1'b1;
                        state_d = CORE;
                        burst_d = 4'd1;
                        last_d  = OWN_HOST;
                    end else begin
                        state_d = IDLE;
                        burst_d = 4'd0;
                        last_d  = OWN_HOST;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            burst_q       <= 4'd0;
            last_q        <= OWN_HOST;
            core_rvalid_q <= 1'b0;
            host_rvalid_q <= 1'b0;
            addr_hold_q   <= '0;
            wdata_hold_q  <= '0;
        end else begin
            state_q       <= state_d;
            burst_q       <= burst_d;
            last_q        <= last_d;
            core_rvalid_q <= gnt_c & ~core_we;
            host_rvalid_q <= gnt_h & ~host_we;
            if (gnt_c || gnt_h) begin
                addr_hold_q  <= mem_addr;
                wdata_hold_q <= mem_wdata;
            end
        end
    end

    assign core_gnt  = gnt_c;
    assign host_gnt  = gnt_h;
    assign mem_en    = gnt_c | gnt_h;
    assign mem_we    = (gnt_c & core_we) | (gnt_h & host_we);
    assign mem_addr  = gnt_c ? core_addr  : (gnt_h ? host_addr  : addr_hold_q);
    assign mem_wdata = gnt_c ? core_wdata : (gnt_h ? host_wdata : wdata_hold_q);

    // A reset arriving while a read is in flight suppresses its return pulse
    assign core_rvalid = core_rvalid_q & ~sys_rst;
    assign host_rvalid = host_rvalid_q & ~sys_rst;
    assign core_rdata  = mem_rdata;
    assign host_rdata  = mem_rdata;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        core_req, core_we, host_req, host_we;
    logic [3:0]  core_addr, host_addr, mem_addr;
    logic [15:0] core_wdata, host_wdata, mem_wdata, mem_rdata;
    logic        core_gnt, core_rvalid, host_gnt, host_rvalid;
    logic [15:0] core_rdata, host_rdata;
    logic        mem_en, mem_we, busy;
    logic [15:0] ram [16];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(16), .ADDR_W(4), .MAX_BURST(4)) dut (
        .clk(clk), .sys_rst(sys_rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Single-port RAM, one-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input logic req, input logic we, input logic [3:0] a, input logic [15:0] d);
        core_req = req; core_we = we; core_addr = a; core_wdata = d;
    endtask

    task automatic set_host(input logic req, input logic we, input logic [3:0] a, input logic [15:0] d);
        host_req = req; host_we = we; host_addr = a; host_wdata = d;
    endtask

    // Advance to the next negedge; inputs set afterwards are sampled at the following posedge
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        set_core(0, 0, 0, 0);
        set_host(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pat [10];
        pat = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 16; i++) ram[i] = 16'h0;
        mem_rdata = 16'h0;

        // Reset: combinational outputs forced low while sys_rst is high
        sys_rst = 1'b1;
        set_core(0, 0, 0, 0);
        set_host(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        cyc();
        set_core(1, 1, 4'd1, 16'h5555);
        set_host(1, 1, 4'd2, 16'h6666);
        #1;
        check("rst_core_gnt", core_gnt, 0);
        check("rst_host_gnt", host_gnt, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_busy", busy, 0);
        check("rst_core_rvalid", core_rvalid, 0);
        check("rst_host_rvalid", host_rvalid, 0);
        set_core(0, 0, 0, 0);
        set_host(0, 0, 0, 0);
        sys_rst = 1'b0;

        // Core write 3 = ABCD then read 3
        cyc(); set_core(1, 1, 4'd3, 16'hABCD); #1;
        check("t1_wr_gnt", core_gnt, 1);
        check("t1_wr_mem_en", mem_en, 1);
        check("t1_wr_mem_we", mem_we, 1);
        check("t1_wr_mem_addr", mem_addr, 3);
        check("t1_wr_mem_wdata", mem_wdata, 16'hABCD);
        check("t1_wr_host_gnt", host_gnt, 0);
        cyc(); set_core(1, 0, 4'd3, 16'h0); #1;
        check("t1_rd_gnt", core_gnt, 1);
        check("t1_rd_mem_we", mem_we, 0);
        cyc(); set_core(0, 0, 0, 0); #1;
        check("t1_rvalid", core_rvalid, 1);
        check("t1_rdata", core_rdata, 16'hABCD);
        check("t1_host_rvalid", host_rvalid, 0);
        check("t1_no_gnt_mem_en", mem_en, 0);
        check("t1_no_gnt_mem_we", mem_we, 0);
        check("t1_busy_before_idle", busy, 1);
        cyc(); #1;
        check("t1_rvalid_one_cycle", core_rvalid, 0);
        check("t1_busy_idle", busy, 0);

        // Both requesting continuously: C,C,C,C,H,H,H,H,C,C
        do_reset();
        set_core(1, 0, 4'd0, 16'h0);
        set_host(1, 0, 4'd0, 16'h0);
        #1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin cyc(); #1; end
            check($sformatf("t2_core_gnt_%0d", i), core_gnt, pat[i] == 0);
            check($sformatf("t2_host_gnt_%0d", i), host_gnt, pat[i] == 1);
            if (i > 0) check($sformatf("t2_busy_%0d", i), busy, 1);
        end
        set_core(0, 0, 0, 0);
        set_host(0, 0, 0, 0);

        // Host alone for 20 cycles, then core joins: saturated burst hands over at once
        do_reset();
        set_host(1, 0, 4'd1, 16'h0);
        #1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin cyc(); #1; end
            check($sformatf("t3_host_gnt_%0d", i), host_gnt, 1);
            check($sformatf("t3_core_gnt_%0d", i), core_gnt, 0);
        end
        cyc(); set_core(1, 0, 4'd1, 16'h0); #1;
        check("t3_switch_core_gnt", core_gnt, 1);
        check("t3_switch_host_gnt", host_gnt, 0);
        cyc(); set_core(0, 0, 0, 0); set_host(0, 0, 0, 0); #1;
        check("t3_drop_gnt", core_gnt | host_gnt, 0);
        check("t3_drop_busy", busy, 1);
        cyc(); #1;
        check("t3_idle_busy", busy, 0);

        // Tie-break follows history
        do_reset();
        set_host(1, 0, 4'd2, 16'h0); #1;
        check("t4_host_first", host_gnt, 1);
        cyc(); set_host(0, 0, 0, 0); #1;
        check("t4_gap_no_gnt", mem_en, 0);
        cyc(); set_core(1, 0, 4'd2, 16'h0); set_host(1, 0, 4'd2, 16'h0); #1;
        check("t4_tie_core", core_gnt, 1);
        check("t4_tie_core_h", host_gnt, 0);
        cyc(); set_core(0, 0, 0, 0); set_host(0, 0, 0, 0); #1;
        check("t4_gap2_no_gnt", mem_en, 0);
        cyc(); set_core(1, 0, 4'd2, 16'h0); set_host(1, 0, 4'd2, 16'h0); #1;
        check("t4_tie_host", host_gnt, 1);
        check("t4_tie_host_c", core_gnt, 0);
        cyc(); set_core(0, 0, 0, 0); set_host(0, 0, 0, 0);

        // Host read of 5 then core write of 5: read sees old value
        do_reset();
        set_host(1, 1, 4'd5, 16'h1111); #1;
        check("t5_host_wr_gnt", host_gnt, 1);
        cyc(); set_host(1, 0, 4'd5, 16'h0); #1;
        check("t5_host_rd_gnt", host_gnt, 1);
        cyc(); set_host(0, 0, 0, 0); set_core(1, 1, 4'd5, 16'h2222); #1;
        check("t5_core_wr_gnt", core_gnt, 1);
        check("t5_host_rvalid", host_rvalid, 1);
        check("t5_host_rdata_old", host_rdata, 16'h1111);
        cyc(); set_core(0, 0, 0, 0); set_host(1, 0, 4'd5, 16'h0); #1;
        check("t5_host_rd2_gnt", host_gnt, 1);
        check("t5_host_rvalid_gap", host_rvalid, 0);
        cyc(); set_host(0, 0, 0, 0); #1;
        check("t5_host_rvalid2", host_rvalid, 1);
        check("t5_host_rdata_new", host_rdata, 16'h2222);
        check("t5_core_rvalid", core_rvalid, 0);

        // Reset right after a core read grant, mid-burst
        do_reset();
        set_core(1, 0, 4'd3, 16'h0); #1;
        check("t6_rd1_gnt", core_gnt, 1);
        cyc(); set_host(1, 0, 4'd3, 16'h0); #1;
        check("t6_rd2_gnt", core_gnt, 1);
        cyc(); sys_rst = 1'b1; #1;
        check("t6_rst_rvalid", core_rvalid, 0);
        check("t6_rst_gnt", core_gnt | host_gnt, 0);
        cyc(); #1;
        check("t6_post_rvalid", core_rvalid, 0);
        check("t6_post_busy", busy, 0);
        sys_rst = 1'b0; #1;
        check("t6_post_rvalid2", core_rvalid, 0);
        check("t6_tie_core", core_gnt, 1);
        check("t6_tie_core_h", host_gnt, 0);
        cyc(); set_core(0, 0, 0, 0); set_host(0, 0, 0, 0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
